// File: rtl/path_gen_if.sv
// path_gen_if: parameter/sample/result bundle for the Monte-Carlo path generator.
//
// Signals:
//   start    1  single-cycle pulse that begins a path
//   w       12  drift per step, signed Q0.11
//   q       12  volatility*sqrt(dt), unsigned Q0.12
//   S0      12  initial price, unsigned integer
//   epsilon 13  standard-normal sample, signed Q3.9
//   valid    1  path carries a path sample
//   path    12  current path price, unsigned integer
//
// master drives parameters/samples and observes results; slave is path_gen.
interface path_gen_if;
    logic        start;
    logic [11:0] w;
    logic [11:0] q;
    logic [11:0] S0;
    logic [12:0] epsilon;
    logic        valid;
    logic [11:0] path;

    modport master (
        output start, w, q, S0, epsilon,
        input  valid, path
    );

    modport slave (
        input  start, w, q, S0, epsilon,
        output valid, path
    );
endinterface

// File: rtl/path_gen.sv
// path_gen: Monte-Carlo asset-path generator (8-step Euler GBM).
//
// On start the block captures w, q and S0 on the following (LOAD) edge and
// accepts one epsilon per cycle for 8 cycles. Each sample runs through a
// 3-stage pipeline:
//   P1  prod = q*eps (Q3.21), kept as prod >>> 10 (Q3.11)
//   P2  F = 2048 + w + prod>>>10, forced to 0 when negative
//   P3  S_next = (S*F) >> 11, S = S0 for the first sample of a path
// and path/valid present S(k+1) three edges after eps(k) is accepted.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, ACTIVE-HIGH (legacy name kept)
//   bus    path_gen_if.slave: start, w, q, S0, epsilon in; valid, path out
//
// Build option:
//   PATH_SAT_EN  defined   -> S_next above 4095 clamps to 4095
//                undefined -> S_next keeps its low 12 bits (wraps mod 4096)
module path_gen (
    input  logic      clk,
    input  logic      rst_n,
    path_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    // ------------------------------------------------------------------
    // Control / parameter registers
    // ------------------------------------------------------------------
    state_t      state;
    logic [2:0]  step;      // index of the sample accepted on the next RUN edge
    logic [11:0] w_reg;
    logic [11:0] q_reg;
    logic [11:0] s0_reg;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic               p1_valid;
    logic               p1_first;
    logic signed [15:0] p1_prod;   // q*eps >>> 10, Q3.11
    logic [11:0]        p1_w;      // drift travels with its sample

    logic               p2_valid;
    logic               p2_first;
    logic [14:0]        p2_f;      // growth factor, Q3.11, never negative

    logic               valid_q;
    logic [11:0]        path_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic               accept;
    logic [11:0]        q_sel;
    logic [11:0]        w_sel;
    logic signed [25:0] prod_full;
    logic signed [17:0] f_sum;
    logic [14:0]        f_clamp;
    logic [11:0]        s_sel;
    logic [26:0]        s_prod;
    logic [15:0]        s_scaled;
    logic [11:0]        s_next;

    always_comb begin
        accept = (state == LOAD) || (state == RUN);

        // eps(0) arrives on the same edge the parameters are captured, so the
        // LOAD sample multiplies by the live inputs rather than the registers.
        q_sel = (state == LOAD) ? bus.q : q_reg;
        w_sel = (state == LOAD) ? bus.w : w_reg;

        prod_full = $signed({14'd0, q_sel}) *
                    $signed({{13{bus.epsilon[12]}}, bus.epsilon});

        f_sum = 18'sd2048
              + $signed({{6{p1_w[11]}}, p1_w})
              + $signed({{2{p1_prod[15]}}, p1_prod});
        f_clamp = (f_sum < 0) ? '0 : 15'(f_sum);

        // The first sample of a path starts from its own latched S0; every
        // later sample chains from the previous result held in path_q.
        s_sel    = p2_first ? s0_reg : path_q;
        s_prod   = {15'd0, s_sel} * {12'd0, p2_f};
        s_scaled = 16'(s_prod >> 11);

`ifdef PATH_SAT_EN
        s_next = (s_scaled > 16'd4095) ? 12'hFFF : 12'(s_scaled);
`else
        s_next = 12'(s_scaled);
`endif
    end

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> LOAD -> RUN (7 samples) -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= IDLE;
            step   <= '0;
            w_reg  <= '0;
            q_reg  <= '0;
            s0_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    w_reg  <= bus.w;
                    q_reg  <= bus.q;
                    s0_reg <= bus.S0;
                    step   <= 3'd1;
                    state  <= RUN;
                end
                RUN: begin
                    if (step == 3'd7) begin
                        state <= IDLE;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            p1_valid <= 1'b0;
            p1_first <= 1'b0;
            p1_prod  <= '0;
            p1_w     <= '0;
            p2_valid <= 1'b0;
            p2_first <= 1'b0;
            p2_f     <= '0;
            valid_q  <= 1'b0;
            path_q   <= '0;
        end else begin
            p1_valid <= accept;
            p1_first <= (state == LOAD);
            if (accept) begin
                p1_prod <= 16'(prod_full >>> 10);
                p1_w    <= w_sel;
            end

            p2_valid <= p1_valid;
            p2_first <= p1_first;
            if (p1_valid) begin
                p2_f <= f_clamp;
            end

            valid_q <= p2_valid;
            if (p2_valid) begin
                path_q <= s_next;
            end
        end
    end

    assign bus.valid = valid_q;
    assign bus.path  = path_q;

endmodule

// File: tb/tb_path_gen.sv
// tb_path_gen: self-checking bench for path_gen.
//
// Each scenario builds a per-cycle stimulus plan (inputs and expected
// valid/path after each rising edge), then replays it, comparing the DUT
// every cycle. Expected prices come from a plain-integer GBM Euler model
// or from literal tables for the directed cases.
module tb_path_gen;

    localparam int NC = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    path_gen_if bus ();

    path_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int last_path = 0;

    // Per-cycle plan
    bit          in_start [NC];
    bit          in_rst   [NC];
    logic [11:0] in_w     [NC];
    logic [11:0] in_q     [NC];
    logic [11:0] in_s0    [NC];
    logic [12:0] in_eps   [NC];
    bit          exp_valid[NC];
    int          exp_val  [NC];
    int          plan_len;
    int          cur_eps  [8];

    int dir_s0 [5] = '{1000, 1024, 100, 500, 4000};
    int dir_w  [5] = '{0, 256, 0, 2048, 1024};
    int dir_q  [5] = '{0, 0, 2048, 0, 0};
    int dir_tbl[4][8] = '{
        '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000},
        '{1152, 1296, 1458, 1640, 1845, 2075, 2334, 2625},
        '{150, 225, 337, 505, 757, 1135, 1702, 2553},
        '{0, 0, 0, 0, 0, 0, 0, 0}
    };
`ifdef PATH_SAT_EN
    int ovf_tbl[8] = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
`else
    int ovf_tbl[8] = '{1904, 2856, 188, 282, 423, 634, 951, 1426};
`endif

    // ------------------------------------------------------------------
    // Reference model helpers
    // ------------------------------------------------------------------
    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic int floor_div(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic void plan_reset();
        for (int c = 0; c < NC; c++) begin
            in_start[c]  = 1'b0;
            in_rst[c]    = 1'b0;
            in_w[c]      = 12'($urandom);
            in_q[c]      = 12'($urandom);
            in_s0[c]     = 12'($urandom);
            in_eps[c]    = 13'($urandom);
            exp_valid[c] = 1'b0;
            exp_val[c]   = 0;
        end
        plan_len = 0;
    endfunction

    function automatic void plan_truncate(input int c0);
        for (int c = c0; c < NC; c++) begin
            in_start[c]  = 1'b0;
            exp_valid[c] = 1'b0;
        end
    endfunction

    // Schedules a path whose start is sampled at edge s, using cur_eps.
    function automatic void plan_path(input int s, input int s0, input int wv, input int qv);
        int price;
        int f;
        price = s0;
        in_start[s] = 1'b1;
        in_w[s+1]   = 12'(wv);
        in_q[s+1]   = 12'(qv);
        in_s0[s+1]  = 12'(s0);
        for (int k = 0; k < 8; k++) begin
            in_eps[s+1+k] = 13'(cur_eps[k]);
            if ($urandom_range(0, 3) == 0) in_start[s+1+k] = 1'b1;  // busy: ignored
            f = 2048 + sx(wv, 12) + floor_div(qv * sx(cur_eps[k], 13), 1024);
            if (f < 0) f = 0;
            price = (price * f) / 2048;
`ifdef PATH_SAT_EN
            if (price > 4095) price = 4095;
`else
            price = price % 4096;
`endif
            exp_valid[s+3+k] = 1'b1;
            exp_val[s+3+k]   = price;
        end
        if (s + 12 > plan_len) plan_len = s + 12;
    endfunction

    function automatic void rand_eps(input bit wide);
        for (int k = 0; k < 8; k++) begin
            if (wide) cur_eps[k] = int'($urandom_range(0, 8191));
            else      cur_eps[k] = (int'($urandom_range(0, 2048)) - 1024) & 8191;
        end
    endfunction

    task automatic drive_cycle(input int c);
        bus.start   = in_start[c];
        bus.w       = in_w[c];
        bus.q       = in_q[c];
        bus.S0      = in_s0[c];
        bus.epsilon = in_eps[c];
        rst_n       = in_rst[c];
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.start   = 1'b1;
        bus.w       = 12'h3A5;
        bus.q       = 12'h7C1;
        bus.S0      = 12'd999;
        bus.epsilon = 13'h0123;
        rst_n       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid !== 1'b0 || bus.path !== 12'd0)
                $display("FAIL reset cyc=%0d: valid=%b path=%0d, expected valid=0 path=0",
                         i, bus.valid, bus.path);
            if (bus.valid !== 1'b0 || bus.path !== 12'd0) errors++;
        end
        bus.start = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid !== 1'b0 || bus.path !== 12'd0) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d: valid=%b path=%0d, expected valid=0 path=0",
                         i, bus.valid, bus.path);
            end
        end
        last_path = 0;
    endtask

    task automatic test_directed();
        for (int i = 0; i < 5; i++) begin
            plan_reset();
            if (i == 2) begin
                for (int k = 0; k < 8; k++) cur_eps[k] = 12'h200;
            end else begin
                rand_eps(1'b1);
            end
            plan_path(0, dir_s0[i], dir_w[i], dir_q[i]);
            for (int k = 0; k < 8; k++)
                exp_val[3+k] = (i == 4) ? ovf_tbl[k] : dir_tbl[i][k];
            for (int c = 0; c < plan_len; c++) begin
                drive_cycle(c);
                if (exp_valid[c]) last_path = exp_val[c];
                checks++;
                if (bus.valid !== exp_valid[c] || bus.path !== 12'(last_path)) begin
                    errors++;
                    $display("FAIL directed%0d cyc=%0d: valid=%b path=%0d, expected valid=%b path=%0d",
                             i, c, bus.valid, bus.path, exp_valid[c], last_path);
                end
            end
        end
    endtask

    task automatic test_random();
        int s;
        for (int r = 0; r < 4; r++) begin
            plan_reset();
            s = 0;
            for (int p = 0; p < 5; p++) begin
                rand_eps(p[0]);
                if (p[0])
                    plan_path(s, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                              int'($urandom_range(0, 4095)));
                else
                    plan_path(s, int'($urandom_range(0, 4095)),
                              (int'($urandom_range(0, 511)) - 256) & 4095,
                              int'($urandom_range(0, 1023)));
                s += int'($urandom_range(9, 14));
            end
            for (int c = 0; c < plan_len; c++) begin
                drive_cycle(c);
                if (exp_valid[c]) last_path = exp_val[c];
                checks++;
                if (bus.valid !== exp_valid[c] || bus.path !== 12'(last_path)) begin
                    errors++;
                    $display("FAIL random%0d cyc=%0d: valid=%b path=%0d, expected valid=%b path=%0d",
                             r, c, bus.valid, bus.path, exp_valid[c], last_path);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int nvalid;
        nvalid = 0;
        plan_reset();
        rand_eps(1'b0);
        plan_path(0, 2000, 64, 700);
        rand_eps(1'b0);
        plan_path(9, 300, (-100) & 4095, 1500);
        for (int c = 0; c < plan_len; c++) begin
            drive_cycle(c);
            if (exp_valid[c]) last_path = exp_val[c];
            if (bus.valid === 1'b1) nvalid++;
            checks++;
            if (bus.valid !== exp_valid[c] || bus.path !== 12'(last_path)) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d: valid=%b path=%0d, expected valid=%b path=%0d",
                         c, bus.valid, bus.path, exp_valid[c], last_path);
            end
        end
        checks++;
        if (nvalid != 16) begin
            errors++;
            $display("FAIL back_to_back_count: valid cycles=%0d, expected 16", nvalid);
        end
    endtask

    task automatic test_reset_mid();
        plan_reset();
        rand_eps(1'b0);
        plan_path(0, 3000, 32, 400);
        plan_truncate(5);
        in_rst[5] = 1'b1;
        rand_eps(1'b0);
        plan_path(7, 1234, (-20) & 4095, 900);
        for (int c = 0; c < plan_len; c++) begin
            drive_cycle(c);
            if (in_rst[c]) last_path = 0;
            else if (exp_valid[c]) last_path = exp_val[c];
            checks++;
            if (bus.valid !== exp_valid[c] || bus.path !== 12'(last_path)) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d: valid=%b path=%0d, expected valid=%b path=%0d",
                         c, bus.valid, bus.path, exp_valid[c], last_path);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
